tlp_rx_arbiter: RTL and testbench
=================================

# tlp_rx_arbiter

Packet-granular arbiter sharing the single AXI-stream input of the axi2ocp bridge between two TLP receive FIFOs: source 0 for posted traffic, source 1 for non-posted traffic. The grant is locked for a whole TLP from first beat to `tlast`, so headers and payload of different packets never interleave at the bridge. It sits directly upstream of axi2ocp and also provides per-source packet counters and a stall watchdog for debug.

## Interface
- `DATA_W`, 64: stream data width; matches the bridge FIFO width.
- `KEEP_W`, 8: tkeep width; equals `DATA_W`/8.
- `CNT_W`, 16: packet counter width.
- `STALL_LIMIT`, 255: consecutive mid-packet idle cycles on the granted source before `stall_err` sets.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s0_axis_tvalid` / `s1_axis_tvalid`  in  1  source valid.
- `s0_axis_tready` / `s1_axis_tready`  out  1  source ready.
- `s0_axis_tdata` / `s1_axis_tdata`  in  DATA_W  source data.
- `s0_axis_tkeep` / `s1_axis_tkeep`  in  KEEP_W  source byte enables.
- `s0_axis_tlast` / `s1_axis_tlast`  in  1  last beat of TLP.
- `m_axis_tvalid`  out  1  to bridge.
- `m_axis_tready`  in  1  from bridge.
- `m_axis_tdata`  out  DATA_W  to bridge.
- `m_axis_tkeep`  out  KEEP_W  to bridge.
- `m_axis_tlast`  out  1  to bridge.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `pkt_cnt0` / `pkt_cnt1`  out  CNT_W  completed TLPs per source.
- `stall_err`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - No valid source: stay in IDLE.
  - One valid source: go to that source's OWN state.
  - Both valid: round-robin against the `last` pointer. The source not served last wins. `last` resets to 1, so source 0 wins first.
- OWNx:
  - `m_axis_*` is a combinational mux of source x.
  - `sx_axis_tready` = `m_axis_tready`; the other source's tready = 0.
  - A beat transfers when `sx_axis_tvalid & m_axis_tready`.
- On a transfer with `tlast` = 1:
  - Increment `pkt_cntx`; it wraps modulo 2^CNT_W.
  - Set `last` = x.
  - Go to IDLE.
- IDLE outputs: all `m_axis_*` = 0, both treadys = 0, `grant` = 00.
- Watchdog:
  - Counter runs in OWNx only. It increments each cycle with `sx_axis_tvalid` = 0 and clears on any cycle with tvalid = 1.
  - When the counter reaches `STALL_LIMIT`, `stall_err` sets and stays set until reset.
  - Grant is not revoked; the packet must still complete.
  - The counter saturates and clears on entry to IDLE.
- Bridge backpressure (`m_axis_tready` = 0 with tvalid = 1) is not a stall and does not advance the watchdog.
- A source asserting tvalid while not granted waits. Its data must be held per AXI-stream rules; the arbiter never drops it.

## Timing
- Reset values (asserted asynchronously, regardless of clock):
  - FSM = IDLE, `last` = 1.
  - Counters = 0, `stall_err` = 0, `grant` = 00.
  - All tready and `m_axis_*` outputs = 0.
- Reset mid-packet aborts the packet; no partial count is kept.
- Arbitration latency: a request seen in IDLE at edge N gives `grant` and the mux valid from N+1.
  - Zero added data latency while owned (combinational path).
- One mandatory IDLE bubble follows every `tlast` beat. Back-to-back TLPs therefore cost 1 cycle each.
- A single-beat TLP (first beat carries `tlast`) is legal and occupies OWNx for exactly one transfer cycle.
- `tlast` and a new request from the other source in the same cycle: the other source wins the following IDLE (round-robin).

## Configuration
- `TLP_ARB_STRICT_PRIO_EN` defined: in IDLE with both sources valid, source 0 always wins. The `last` pointer is still maintained but ignored.
- Undefined (default): round-robin as above.

## Structure
- Package `tlp_arb_pkg` holds:
  - FSM state typedef/localparams (IDLE, OWN0, OWN1).
  - Grant encodings.
  - Default `DATA_W`/`KEEP_W`, shared with the axi2ocp `fifo_wdth`/`data_wdth` values.
- One sub-module, `rr_pick2`: combinational 2-way pick from (req[1:0], last, strict); returns a one-hot winner. The macro is resolved in the top and passed in as `strict`.
- Watchdog counter and packet counters are inline in the top.

## Test plan
- **Single source:** 3-beat TLP on s0 (tdata 0x11, 0x22, 0x33; last on beat 3), `m_axis_tready` = 1 -> `grant` = 01 from the cycle after tvalid, 3 beats out unchanged, `pkt_cnt0` = 1, then `grant` = 00 for 1 cycle.
- **Contention:** both sources hold 2-beat TLPs continuously -> grant order 01, 10, 01, 10 with one IDLE cycle between each; beats never interleave.
  - With `TLP_ARB_STRICT_PRIO_EN`: grant stays 01 every arbitration.
- **Backpressure:** toggle `m_axis_tready` every cycle during a 4-beat s1 TLP -> exactly 4 transfers, 8 cycles owned, `stall_err` stays 0.
- **Stall:** `STALL_LIMIT` = 4; s0 sends 1 beat, then tvalid is low 4 cycles -> `stall_err` = 1 on cycle 4 and stays set. The remaining beat with `tlast` completes and `pkt_cnt0` increments.
- **Reset mid-packet:** drop `reset` low during beat 2 of 3 -> all outputs 0 immediately, counters 0. After release, a fresh s1 request is granted first-come.
- **Counter wrap:** `CNT_W` = 4; 17 single-beat TLPs on s0 -> `pkt_cnt0` = 1.

Source files
------------

// File: rtl/tlp_rx_arbiter_pkg.sv
// Shared types and defaults for the TLP receive arbiter.
// Stream widths follow the axi2ocp bridge FIFO (fifo_wdth/data_wdth).
package tlp_arb_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_KEEP_W = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

endpackage

// File: rtl/tlp_rx_arbiter_if.sv
// AXI-stream bundle used for both arbiter source ports and the bridge-facing port.
interface tlp_rx_arbiter_if
  import tlp_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEEP_W = DEF_KEEP_W
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);

endinterface

// File: rtl/tlp_rx_arbiter_rr_pick2.sv
// Two-way request picker: one-hot winner from req, last-served pointer and a
// strict-priority override that always favours source 0 on contention.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       strict,
  output logic [1:0] win
);

  // Winner selection
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01: win = 2'b01;
      2'b10: win = 2'b10;
      2'b11: begin
        if (strict || last) begin
          win = 2'b01;
        end else begin
          win = 2'b10;
        end
      end
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/tlp_rx_arbiter.sv
// Packet-locked arbiter merging posted (s0) and non-posted (s1) TLP streams.
// Define TLP_ARB_STRICT_PRIO_EN to make s0 win every contended arbitration.
module tlp_rx_arbiter
  import tlp_arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int KEEP_W      = DEF_KEEP_W,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  tlp_rx_arbiter_if.slave      s0_axis,
  tlp_rx_arbiter_if.slave      s1_axis,
  tlp_rx_arbiter_if.master     m_axis,
  output logic [1:0]           grant,
  output logic [CNT_W-1:0]     pkt_cnt0,
  output logic [CNT_W-1:0]     pkt_cnt1,
  output logic                 stall_err
);

  localparam int WD_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_LIMIT);

`ifdef TLP_ARB_STRICT_PRIO_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;

  logic [1:0]        pick_s;
  logic              sel_vld_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [KEEP_W-1:0] sel_keep_s;
  logic              rdy0_s;
  logic              rdy1_s;

  rr_pick2 u_pick (
    .req    ({s1_axis.tvalid, s0_axis.tvalid}),
    .last   (last_q),
    .strict (STRICT),
    .win    (pick_s)
  );

  // Owner mux: zero added latency from the granted source to the bridge
  always_comb begin
    grant      = GNT_NONE;
    sel_vld_s  = 1'b0;
    sel_last_s = 1'b0;
    sel_data_s = '0;
    sel_keep_s = '0;
    rdy0_s     = 1'b0;
    rdy1_s     = 1'b0;
    case (state_q)
      ST_OWN0: begin
        grant      = GNT_S0;
        sel_vld_s  = s0_axis.tvalid;
        sel_last_s = s0_axis.tlast;
        sel_data_s = s0_axis.tdata;
        sel_keep_s = s0_axis.tkeep;
        rdy0_s     = m_axis.tready;
      end
      ST_OWN1: begin
        grant      = GNT_S1;
        sel_vld_s  = s1_axis.tvalid;
        sel_last_s = s1_axis.tlast;
        sel_data_s = s1_axis.tdata;
        sel_keep_s = s1_axis.tkeep;
        rdy1_s     = m_axis.tready;
      end
      default: grant = GNT_NONE;
    endcase
  end

  assign m_axis.tvalid  = sel_vld_s;
  assign m_axis.tlast   = sel_last_s;
  assign m_axis.tdata   = sel_data_s;
  assign m_axis.tkeep   = sel_keep_s;
  assign s0_axis.tready = rdy0_s;
  assign s1_axis.tready = rdy1_s;
  assign pkt_cnt0       = cnt0_q;
  assign pkt_cnt1       = cnt1_q;
  assign stall_err      = err_q;

  // Next state, packet counters and stall watchdog
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (pick_s == GNT_S0) begin
          state_d = ST_OWN0;
        end else if (pick_s == GNT_S1) begin
          state_d = ST_OWN1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (sel_vld_s) begin
          // Bridge backpressure with valid held is not a stall
          wd_d = '0;
          if (m_axis.tready && sel_last_s) begin
            state_d = ST_IDLE;
            if (state_q == ST_OWN0) begin
              cnt0_d = cnt0_q + CNT_W'(1);
              last_d = 1'b0;
            end else begin
              cnt1_d = cnt1_q + CNT_W'(1);
              last_d = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end else begin
          if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
          end else begin
            wd_d = wd_q;
          end
          if (wd_d == WD_MAX) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; last resets to 1 so source 0 wins the first contention
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tlp_rx_arbiter.sv
// Randomised and directed bench for tlp_rx_arbiter against a cycle-level
// behavioural model of ownership, round-robin, counters and the watchdog.
module tb_tlp_rx_arbiter;

  localparam int CW = 4;
  localparam int SL = 4;

`ifdef TLP_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tlp_rx_arbiter_if s0_if ();
  tlp_rx_arbiter_if s1_if ();
  tlp_rx_arbiter_if m_if ();

  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt0;
  logic [CW-1:0] pkt_cnt1;
  logic          stall_err;

  tlp_rx_arbiter #(.CNT_W(CW), .STALL_LIMIT(SL)) dut (
    .clk       (clk),
    .reset     (reset),
    .s0_axis   (s0_if),
    .s1_axis   (s1_if),
    .m_axis    (m_if),
    .grant     (grant),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .stall_err (stall_err)
  );

  // Source drivers
  logic        vld [2];
  logic [63:0] dat [2];
  logic [7:0]  kp  [2];
  logic        lst [2];
  logic        mrdy;
  int blen [2], bidx [2], pnew [2], pmid [2], flen [2];
  int rdy_mode;
  bit plain;

  assign s0_if.tvalid = vld[0];
  assign s0_if.tdata  = dat[0];
  assign s0_if.tkeep  = kp[0];
  assign s0_if.tlast  = lst[0];
  assign s1_if.tvalid = vld[1];
  assign s1_if.tdata  = dat[1];
  assign s1_if.tkeep  = kp[1];
  assign s1_if.tlast  = lst[1];
  assign m_if.tready  = mrdy;

  // Reference model: owner -1 means idle
  int m_own, m_last, m_wd;
  int m_cnt [2];
  bit m_err;
  int arb_log [$];
  logic [63:0] out_q [$];
  int owned_n, xfer_n;
  int done_n [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic raise(input int s);
    if (bidx[s] == 0) blen[s] = (flen[s] != 0) ? flen[s] : int'($urandom_range(1, 4));
    vld[s] = 1'b1;
    dat[s] = plain ? 64'((bidx[s] + 1) * 17) : {$urandom, $urandom};
    kp[s]  = plain ? 8'hFF : 8'($urandom);
    lst[s] = (bidx[s] == blen[s] - 1);
  endtask

  task automatic model_reset();
    m_own = -1; m_last = 1; m_wd = 0; m_err = 1'b0;
    m_cnt = '{0, 0};
  endtask

  task automatic clear_logs();
    arb_log.delete(); out_q.delete();
    owned_n = 0; xfer_n = 0; done_n = '{0, 0};
  endtask

  task automatic drv_reset();
    for (int s = 0; s < 2; s++) begin
      vld[s] = 1'b0; dat[s] = 64'h0; kp[s] = 8'h0; lst[s] = 1'b0; bidx[s] = 0; blen[s] = 1;
    end
    mrdy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drv_reset(); model_reset(); clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock: check outputs mid-cycle, advance model, then update drivers
  task automatic step();
    logic [1:0] eg;
    bit xf [2];
    int w;
    @(negedge clk);
    eg = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    check_eq("grant", grant, eg);
    check_eq("tready0", s0_if.tready, (m_own == 0) ? mrdy : 1'b0);
    check_eq("tready1", s1_if.tready, (m_own == 1) ? mrdy : 1'b0);
    check_eq("m_tvalid", m_if.tvalid, (m_own >= 0) ? vld[m_own] : 1'b0);
    check_eq("m_tdata", m_if.tdata, (m_own >= 0) ? dat[m_own] : 64'h0);
    check_eq("m_tkeep", m_if.tkeep, (m_own >= 0) ? kp[m_own] : 8'h0);
    check_eq("m_tlast", m_if.tlast, (m_own >= 0) ? lst[m_own] : 1'b0);
    check_eq("pkt_cnt0", pkt_cnt0, 64'(m_cnt[0]));
    check_eq("pkt_cnt1", pkt_cnt1, 64'(m_cnt[1]));
    check_eq("stall_err", stall_err, m_err);
    xf = '{1'b0, 1'b0};
    if (m_own < 0) begin
      if (vld[0] && vld[1]) w = STRICT ? 0 : 1 - m_last;
      else if (vld[0]) w = 0;
      else if (vld[1]) w = 1;
      else w = -1;
      if (w >= 0) arb_log.push_back(w);
      m_own = w;
      m_wd = 0;
    end else begin
      int s;
      s = m_own;
      owned_n++;
      if (vld[s]) begin
        m_wd = 0;
        if (mrdy) begin
          xf[s] = 1'b1;
          xfer_n++;
          out_q.push_back(dat[s]);
          if (lst[s]) begin
            m_cnt[s] = (m_cnt[s] + 1) % (1 << CW);
            done_n[s]++;
            m_last = s;
            m_own = -1;
          end
        end
      end else begin
        if (m_wd < SL) m_wd++;
        if (m_wd == SL) m_err = 1'b1;
      end
    end
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      if (xf[s]) begin
        bidx[s] = lst[s] ? 0 : bidx[s] + 1;
        vld[s] = 1'b0;
      end
      if (!vld[s] && (int'($urandom_range(99)) < ((bidx[s] == 0) ? pnew[s] : pmid[s]))) raise(s);
    end
    case (rdy_mode)
      0: mrdy = ($urandom_range(99) < 75);
      1: mrdy = 1'b1;
      default: mrdy = ~mrdy;
    endcase
  endtask

  initial begin
    int budget;
    plain = 1'b1; rdy_mode = 1;
    pnew = '{0, 0}; pmid = '{100, 100}; flen = '{3, 3};
    do_reset();

    // Single 3-beat TLP on s0
    mrdy = 1'b1;
    raise(0);
    step();
    check_eq("t1_grant_first", grant, 2'b01);
    budget = 0;
    while (out_q.size() < 3 && budget < 10) begin step(); budget++; end
    check_eq("t1_beats", out_q.size(), 3);
    if (out_q.size() == 3) begin
      check_eq("t1_beat0", out_q[0], 64'h11);
      check_eq("t1_beat1", out_q[1], 64'h22);
      check_eq("t1_beat2", out_q[2], 64'h33);
    end
    check_eq("t1_bubble", grant, 2'b00);
    check_eq("t1_cnt0", pkt_cnt0, 4'd1);
    step();

    // Contention with continuous 2-beat TLPs on both sources
    do_reset();
    pnew = '{100, 100}; pmid = '{100, 100}; flen = '{2, 2}; rdy_mode = 1; mrdy = 1'b1;
    raise(0); raise(1);
    budget = 0;
    while (arb_log.size() < 4 && budget < 40) begin step(); budget++; end
    check_eq("t2_arbs", arb_log.size(), 4);
    for (int i = 0; i < arb_log.size() && i < 4; i++)
      check_eq("t2_order", arb_log[i], STRICT ? 0 : (i % 2));

    // Backpressure toggling during a 4-beat s1 TLP
    do_reset();
    pnew = '{0, 0}; pmid = '{100, 100}; flen = '{4, 4}; rdy_mode = 2; mrdy = 1'b1;
    raise(1);
    budget = 0;
    while (done_n[1] < 1 && budget < 30) begin step(); budget++; end
    check_eq("t3_xfers", xfer_n, 4);
    check_eq("t3_owned", owned_n, 8);
    check_eq("t3_stall", stall_err, 1'b0);

    // Stall watchdog
    do_reset();
    pnew = '{0, 0}; pmid = '{0, 0}; flen = '{2, 2}; rdy_mode = 1; mrdy = 1'b1;
    raise(0);
    step(); step();
    repeat (3) step();
    check_eq("t4_before", stall_err, 1'b0);
    step();
    check_eq("t4_set", stall_err, 1'b1);
    raise(0);
    step();
    check_eq("t4_sticky", stall_err, 1'b1);
    check_eq("t4_cnt0", pkt_cnt0, 4'd1);
    check_eq("t4_idle", grant, 2'b00);

    // Reset in the middle of a packet
    do_reset();
    pnew = '{0, 0}; pmid = '{100, 100}; flen = '{3, 2}; rdy_mode = 1; mrdy = 1'b1;
    raise(0);
    budget = 0;
    while (done_n[0] < 1 && budget < 10) begin step(); budget++; end
    raise(0);
    step(); step();
    #2 reset = 1'b0;
    #1;
    check_eq("t5_grant", grant, 2'b00);
    check_eq("t5_tready0", s0_if.tready, 1'b0);
    check_eq("t5_mvalid", m_if.tvalid, 1'b0);
    check_eq("t5_mdata", m_if.tdata, 64'h0);
    check_eq("t5_mlast", m_if.tlast, 1'b0);
    check_eq("t5_cnt0", pkt_cnt0, 4'd0);
    drv_reset(); model_reset(); clear_logs();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    mrdy = 1'b1;
    raise(1);
    step();
    check_eq("t5_regrant", grant, 2'b10);
    budget = 0;
    while (done_n[1] < 1 && budget < 10) begin step(); budget++; end
    check_eq("t5_cnt1", pkt_cnt1, 4'd1);

    // Counter wrap with 17 single-beat TLPs
    do_reset();
    pnew = '{100, 0}; pmid = '{100, 0}; flen = '{1, 1}; rdy_mode = 1; mrdy = 1'b1;
    raise(0);
    budget = 0;
    while (done_n[0] < 17 && budget < 200) begin step(); budget++; end
    check_eq("t6_done", done_n[0], 17);
    check_eq("t6_wrap", pkt_cnt0, 4'd1);

    // Randomised traffic
    do_reset();
    plain = 1'b0;
    pnew = '{70, 50}; pmid = '{80, 85}; flen = '{0, 0}; rdy_mode = 0;
    repeat (3000) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
